// File: rtl/sprite_scheduler_if.sv
// Attribute-table write port and VRAM pixel write handshake for the sprite scheduler.
interface sprite_scheduler_if;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [36:0] cfg_attr;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] address;
  logic [8:0]  data;

  modport master (input cfg_we, cfg_idx, cfg_attr, wr_ready,
                  output wr_valid, address, data);
  modport slave  (output cfg_we, cfg_idx, cfg_attr, wr_ready,
                  input wr_valid, address, data);
endinterface

// File: rtl/sprite_scheduler.sv
// Walks the sprite attribute table once per frame_start and streams every
// on-screen sprite pixel (clipped at the right/bottom edge) to VRAM in row-major order.
module sprite_scheduler #(
  parameter int SPRITE_NUM = 6,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  sprite_scheduler_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               overrun
);
  typedef struct packed {
    logic       en;
    logic [7:0] x;
    logic [6:0] y;
    logic [5:0] w;
    logic [5:0] h;
    logic [8:0] pal;
  } attr_t;

  typedef enum logic [2:0] {IDLE, FETCH, DRAW, NEXT, DONE} state_t;

  state_t     state, state_nx;
  attr_t      tbl [SPRITE_NUM];
  attr_t      cur, fetched;
  logic [2:0] idx;
  logic [5:0] row, col;
  logic [8:0] px;
  logic [7:0] py;
  logic       xfer, last_col, last_row, skip, last_slot;

  assign fetched   = tbl[idx];
  assign skip      = !fetched.en || fetched.w == 6'd0 || fetched.h == 6'd0 ||
                     32'(fetched.x) >= SCREEN_W || 32'(fetched.y) >= SCREEN_H;
  assign last_slot = 32'(idx) == SPRITE_NUM - 1;

  assign px       = {1'b0, cur.x} + {3'b0, col};
  assign py       = {1'b0, cur.y} + {2'b0, row};
  assign last_col = (col == cur.w - 6'd1) || (px == 9'(SCREEN_W - 1));
  assign last_row = (row == cur.h - 6'd1) || (py == 8'(SCREEN_H - 1));
  assign xfer     = bus.wr_valid && bus.wr_ready;

  // Address and data come straight from registers, so they stay put while stalled.
  assign bus.address = 16'(32'(py) * SCREEN_W + 32'(px));
  assign bus.data    = cur.pal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      row   <= '0;
      col   <= '0;
      cur   <= '0;
      for (int i = 0; i < SPRITE_NUM; i++) tbl[i] <= '0;
    end else begin
      state <= state_nx;
      // A write landing on the slot being fetched is seen only by later passes.
      if (bus.cfg_we && 32'(bus.cfg_idx) < SPRITE_NUM) tbl[bus.cfg_idx] <= bus.cfg_attr;
      case (state)
        IDLE:  if (frame_start) idx <= '0;
        FETCH: begin
          cur <= fetched;
          row <= '0;
          col <= '0;
        end
        DRAW: if (xfer) begin
          if (last_col) begin
            col <= '0;
            row <= row + 6'd1;
          end else begin
            col <= col + 6'd1;
          end
        end
        NEXT:  if (!last_slot) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    bus.wr_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    overrun      = frame_start;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        overrun = 1'b0;
        if (frame_start) state_nx = FETCH;
      end
      FETCH: state_nx = skip ? NEXT : DRAW;
      DRAW: begin
        bus.wr_valid = 1'b1;
        if (xfer && last_col && last_row) state_nx = NEXT;
      end
      NEXT: state_nx = last_slot ? DONE : FETCH;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized and directed bench for sprite_scheduler against a pixel-list model
// derived from the attribute table and screen bounds.
module tb_sprite_scheduler;
  localparam int N  = 6;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk, rst_n, frame_start, busy, done, overrun;
  sprite_scheduler_if bif ();

  sprite_scheduler #(.SPRITE_NUM(N), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bus(bif),
    .busy(busy), .done(done), .overrun(overrun));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [36:0] mtbl [N];
  logic [24:0] expq [$];
  int          got  [$];
  int vcycles, busy_cnt, done_cnt, ovr_cnt, rmode;
  bit mon_en, held;
  logic [15:0] h_addr;
  logic [8:0]  h_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [36:0] mk(int en, int x, int y, int w, int h, int pal);
    return {1'(en), 8'(x), 7'(y), 6'(w), 6'(h), 9'(pal)};
  endfunction

  // Reference: every sprite pixel that lies on screen, slot order, row-major.
  function automatic void build_expected();
    expq.delete();
    for (int s = 0; s < N; s++) begin
      int en, x, y, w, h, pal;
      en = int'(mtbl[s][36]);    x = int'(mtbl[s][35:28]); y = int'(mtbl[s][27:21]);
      w  = int'(mtbl[s][20:15]); h = int'(mtbl[s][14:9]);  pal = int'(mtbl[s][8:0]);
      if (en != 0)
        for (int r = 0; r < h; r++)
          for (int c = 0; c < w; c++)
            if (x + c < SW && y + r < SH)
              expq.push_back({16'((y + r) * SW + x + c), 9'(pal)});
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bif.wr_ready = 1'b1;
      1:       bif.wr_ready = 1'($urandom_range(0, 1));
      default: bif.wr_ready = (vcycles >= 3);
    endcase
  end

  always @(negedge clk) begin
    if (!mon_en) held = 0;
    else begin
      if (bif.wr_valid) begin
        vcycles++;
        if (held) begin
          check("hold_addr", 32'(bif.address), 32'(h_addr));
          check("hold_data", 32'(bif.data), 32'(h_data));
        end
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_pixel: got address %0d, required no write", bif.address);
        end else begin
          check("pix_addr", 32'(bif.address), 32'(expq[0][24:9]));
          check("pix_data", 32'(bif.data), 32'(expq[0][8:0]));
          if (bif.wr_ready) begin
            got.push_back(int'(bif.address));
            void'(expq.pop_front());
          end
        end
        held = !bif.wr_ready; h_addr = bif.address; h_data = bif.data;
      end else begin
        if (held) check("hold_valid", 32'(bif.wr_valid), 32'd1);
        held = 0;
      end
      if (busy && !done) busy_cnt++;
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic cfg_write(input int idx, input logic [36:0] attr);
    @(posedge clk); #1;
    bif.cfg_we = 1; bif.cfg_idx = 3'(idx); bif.cfg_attr = attr;
    @(posedge clk); #1;
    bif.cfg_we = 0;
    if (idx < N) mtbl[idx] = attr;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) cfg_write(i, '0);
  endtask

  // wr_idx >= 0 writes that slot during the FETCH cycle of slot 0.
  task automatic pass_run(input int rm, input int ovr_at, input int wr_idx,
                          input logic [36:0] wr_attr, input string tag);
    if (wr_idx > 0 && wr_idx < N) mtbl[wr_idx] = wr_attr;
    build_expected();
    if (wr_idx == 0) mtbl[0] = wr_attr;
    got.delete(); vcycles = 0; busy_cnt = 0; done_cnt = 0; ovr_cnt = 0; rmode = rm;
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    if (wr_idx >= 0) begin bif.cfg_we = 1; bif.cfg_idx = 3'(wr_idx); bif.cfg_attr = wr_attr; end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      bif.cfg_we  = 0;
      frame_start = (i == ovr_at);
    end
    frame_start = 0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_left"}, expq.size(), 0);
    check({tag, "_busy"}, busy_cnt, 2 * N + vcycles);
    check({tag, "_overrun"}, ovr_cnt, (ovr_at >= 0) ? 1 : 0);
  endtask

  initial begin
    int lit36 [4] = '{810, 811, 970, 971};
    clk = 0; rst_n = 0; frame_start = 0; rmode = 0; mon_en = 0; held = 0;
    bif.cfg_we = 0; bif.cfg_idx = 0; bif.cfg_attr = 0; bif.wr_ready = 1;
    vcycles = 0; busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    for (int i = 0; i < N; i++) mtbl[i] = '0;
    #12;
    check("rst_wr_valid", 32'(bif.wr_valid), 0);
    check("rst_address", 32'(bif.address), 0);
    check("rst_data", 32'(bif.data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    @(posedge clk); #1 rst_n = 1; mon_en = 1;

    // All slots disabled: nothing written, FETCH+NEXT per slot.
    pass_run(0, -1, -1, '0, "empty");
    check("empty_busy_lit", busy_cnt, 12);
    check("empty_valid", vcycles, 0);

    // Basic 2x2 sprite.
    cfg_write(0, mk(1, 10, 5, 2, 2, 'h1A5));
    build_expected();
    check("model_n", expq.size(), 4);
    check("model_addr0", 32'(expq[0][24:9]), 810);
    check("model_data0", 32'(expq[0][8:0]), 'h1A5);
    pass_run(0, -1, -1, '0, "basic");
    check("basic_n", got.size(), 4);
    for (int i = 0; i < 4; i++) check("basic_lit", (i < got.size()) ? got[i] : -1, lit36[i]);
    check("basic_busy_lit", busy_cnt, 16);

    // Clipped at the bottom-right corner.
    clear_tbl();
    cfg_write(2, mk(1, 158, 119, 4, 3, 'h033));
    pass_run(0, -1, -1, '0, "clip");
    check("clip_n", got.size(), 2);
    check("clip_a0", (got.size() > 0) ? got[0] : -1, 19198);
    check("clip_a1", (got.size() > 1) ? got[1] : -1, 19199);

    // Out-of-range slot index is ignored.
    cfg_write(6, mk(1, 0, 0, 1, 1, 1));
    cfg_write(7, mk(1, 1, 1, 1, 1, 2));
    pass_run(0, -1, -1, '0, "badidx");
    check("badidx_n", got.size(), 2);

    // Backpressure on first pixel.
    clear_tbl();
    cfg_write(0, mk(1, 0, 0, 2, 1, 'h0F0));
    pass_run(2, -1, -1, '0, "stall");
    check("stall_valid_cycles", vcycles, 5);
    check("stall_n", got.size(), 2);

    // frame_start during DRAW.
    cfg_write(0, mk(1, 20, 20, 4, 4, 'h111));
    pass_run(0, 3, -1, '0, "ovr");
    check("ovr_n", got.size(), 16);

    // Same-cycle write to the slot being fetched keeps the old value this pass.
    clear_tbl();
    cfg_write(0, mk(1, 30, 30, 2, 2, 'h077));
    pass_run(0, -1, 0, mk(0, 30, 30, 2, 2, 'h077), "fetchwr");
    check("fetchwr_n", got.size(), 4);
    pass_run(0, -1, -1, '0, "fetchwr2");
    check("fetchwr2_n", got.size(), 0);
    // Write to a slot not yet fetched is honoured this pass.
    pass_run(0, -1, 5, mk(1, 40, 40, 2, 1, 'h099), "latewr");
    check("latewr_n", got.size(), 2);

    // Random tables with random backpressure.
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < N; s++)
        cfg_write(s, mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 170),
                        $urandom_range(0, 125), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 511)));
      pass_run(k % 2, -1, -1, '0, "rand");
    end

    // Asynchronous reset in the middle of DRAW.
    clear_tbl();
    cfg_write(0, mk(1, 0, 0, 20, 20, 'h055));
    mon_en = 0; rmode = 0;
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    for (int i = 0; i < 20 && !bif.wr_valid; i++) @(negedge clk);
    check("rst_pre_valid", 32'(bif.wr_valid), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 0; #1;
    check("arst_wr_valid", 32'(bif.wr_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_address", 32'(bif.address), 0);
    check("arst_data", 32'(bif.data), 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < N; i++) mtbl[i] = '0;
    expq.delete();
    mon_en = 1;
    pass_run(0, -1, -1, '0, "post_rst");
    check("post_rst_valid", vcycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
